rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the two write ports of the 2R/2W register file among NUM_REQ writeback sources (ALU, MUL, LSU, branch unit).
- Grants up to two requesters per cycle using a round-robin pointer.
- Guarantees the two ports never target the same address in the same cycle.
- Registers the granted writes so the register-file write ports are driven from flops.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- OPRAND_WIDTH, 32, data width per write.
- REGNAME_WIDTH, 5, register address width.
- DROP_R0, 1, when 1, requests to address 0 are accepted and discarded without using a port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester write request valid.
- req_addr_i  input  NUM_REQ*REGNAME_WIDTH  per-requester destination address; requester k occupies slice k.
- req_data_i  input  NUM_REQ*OPRAND_WIDTH  per-requester write data; requester k occupies slice k.
- req_ready_o  output  NUM_REQ  combinational accept; valid & ready in a cycle means the request is consumed.
- write1_en_o  output  1  register-file write port 1 enable.
- write1_addr_o  output  REGNAME_WIDTH  port 1 address.
- write1_data_o  output  OPRAND_WIDTH  port 1 data.
- write2_en_o  output  1  register-file write port 2 enable.
- write2_addr_o  output  REGNAME_WIDTH  port 2 address.
- write2_data_o  output  OPRAND_WIDTH  port 2 data.
- busy_o  output  1  registered; 1 when any valid request was left unaccepted in the previous cycle.

Behaviour:
- State: round-robin pointer ptr (0..NUM_REQ-1), write-port output registers, busy_o flop.
- Reset (async, immediate): ptr=0; write1/2_en_o=0; all addr/data outputs 0; busy_o=0; req_ready_o forced 0 while rst=1.
- Candidates: requesters with valid=1, excluding address-0 requests when DROP_R0=1.
- Scan order: ptr, ptr+1, ... modulo NUM_REQ.
- Grant A: first candidate in scan order.
- Grant B: next candidate after A whose address differs from A's address.
- Candidates with the same address as A are skipped this cycle and stay pending; a skipped requester may not be chosen as B.
- Address 0 with DROP_R0=1: ready=1 in the same cycle as valid, independent of A/B; no write is issued; ptr is unaffected.
- req_ready_o[k]=1 only for A, B and dropped-R0 requesters. Requesters must hold valid, addr and data stable until accepted.
- Latency: a request accepted in cycle N appears on the ports in cycle N+1.
  - A drives write1_*; B drives write2_*.
  - If only A exists, write2_en_o=0.
  - If nothing is granted, both enables are 0 and addr/data hold their previous values.
- Pointer update at the clock edge:
  - B granted: ptr = idx(B)+1 mod NUM_REQ.
  - Only A granted: ptr = idx(A)+1 mod NUM_REQ.
  - No grant: ptr unchanged.
  - Wrap-around: a grant at NUM_REQ-1 sets ptr to 0.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/2)+1 cycles, including one same-address deferral.
- Ordering: same-address writes from different requesters land in grant order and never in the same cycle. Upstream rename guarantees program order does not depend on this.
- busy_o <= OR over k of (req_valid_i[k] & ~req_ready_o[k]).
- Reset mid-operation: a write registered but not yet consumed by the RAM is discarded (enables cleared asynchronously). Requesters re-present after reset.

Test Plan:
- Assert rst for 3 cycles with all requests valid -> req_ready_o=0, both enables 0, addr/data 0, busy_o=0; after release, first grants start at requester 0.
- Only req2 valid, addr 5, data 0xDEADBEEF, ptr=0 -> req_ready_o=4'b0100 that cycle; next cycle write1_en_o=1, addr 5, data 0xDEADBEEF, write2_en_o=0; ptr=3.
- All 4 valid, addrs 1/2/3/4, ptr=0, each requester drops valid after acceptance:
  - Cycle 1: ready=4'b0011.
  - Cycle 2: ports show addr1 on port 1 and addr2 on port 2; ready=4'b1100.
  - Cycle 3: addr3/addr4 on the ports; ptr wraps to 0.
- req0 and req1 both addr 7, req2 addr 9, ptr=0:
  - Cycle 1: ready=4'b0101.
  - Next cycle: port 1 writes addr 7 (req0 data), port 2 writes addr 9; busy_o=1; req1 is then granted on port 1.
- DROP_R0=1, req1 addr 0 and req3 addr 6 both valid -> ready=4'b1010 in the same cycle; only write1 is issued (addr 6); ptr=0 (3+1 wraps).
- Accept two writes, then pulse rst mid-cycle before the next edge -> write1/2_en_o drop to 0 immediately and no RAM write occurs; ptr=0; after release, arbitration resumes from requester 0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// ============================================================================
// rf_write_arbiter_if : writeback request bus and register-file write ports
// Rev 1.0
// ============================================================================
`default_nettype none

interface rf_write_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int OPRAND_WIDTH  = 32,
    parameter int REGNAME_WIDTH = 5
);
    logic [NUM_REQ-1:0]               req_valid_i;
    logic [NUM_REQ*REGNAME_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*OPRAND_WIDTH-1:0]  req_data_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic                             write1_en_o;
    logic [REGNAME_WIDTH-1:0]         write1_addr_o;
    logic [OPRAND_WIDTH-1:0]          write1_data_o;
    logic                             write2_en_o;
    logic [REGNAME_WIDTH-1:0]         write2_addr_o;
    logic [OPRAND_WIDTH-1:0]          write2_data_o;
    logic                             busy_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, write1_en_o, write1_addr_o, write1_data_o,
        input  write2_en_o, write2_addr_o, write2_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, write1_en_o, write1_addr_o, write1_data_o,
        output write2_en_o, write2_addr_o, write2_data_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// rf_write_arbiter : round-robin 2-of-N writeback arbiter for a 2W register file
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int OPRAND_WIDTH  = 32,
    parameter int REGNAME_WIDTH = 5,
    parameter int DROP_R0       = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rf_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]         r_ptr;
    logic                     r_w1_en, r_w2_en, r_busy;
    logic [REGNAME_WIDTH-1:0] r_w1_addr, r_w2_addr;
    logic [OPRAND_WIDTH-1:0]  r_w1_data, r_w2_data;

    logic [REGNAME_WIDTH-1:0] w_addr [NUM_REQ];
    logic [OPRAND_WIDTH-1:0]  w_data [NUM_REQ];
    logic [NUM_REQ-1:0]       w_cand, w_drop, w_grant, w_ready;
    logic                     w_a_vld, w_b_vld;
    logic [PTR_W-1:0]         w_a_idx, w_b_idx, w_ptr_nxt;
    logic [REGNAME_WIDTH-1:0] w_a_addr;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
            assign w_addr[k] = bus.req_addr_i[k*REGNAME_WIDTH +: REGNAME_WIDTH];
            assign w_data[k] = bus.req_data_i[k*OPRAND_WIDTH +: OPRAND_WIDTH];
            // Writes to r0 are absorbed here and never occupy a port
            assign w_drop[k] = (DROP_R0 != 0) && bus.req_valid_i[k] && (w_addr[k] == '0);
            assign w_cand[k] = bus.req_valid_i[k] && !w_drop[k];
        end
    endgenerate

    always_comb begin
        int               j;
        logic [PTR_W-1:0] idx;
        j        = 0;
        idx      = '0;
        w_a_vld  = 1'b0;
        w_b_vld  = 1'b0;
        w_a_idx  = '0;
        w_b_idx  = '0;
        w_a_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = PTR_W'(j);
            if (w_cand[idx]) begin
                if (!w_a_vld) begin
                    w_a_vld  = 1'b1;
                    w_a_idx  = idx;
                    w_a_addr = w_addr[idx];
                end else if (!w_b_vld && (w_addr[idx] != w_a_addr)) begin
                    w_b_vld = 1'b1;
                    w_b_idx = idx;
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((w_a_vld && (w_a_idx == PTR_W'(k))) || (w_b_vld && (w_b_idx == PTR_W'(k))))
                w_grant[k] = 1'b1;
        end
        w_ready = rst ? '0 : (w_grant | w_drop);
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_b_vld)
            w_ptr_nxt = (w_b_idx == c_LAST) ? '0 : w_b_idx + 1'b1;
        else if (w_a_vld)
            w_ptr_nxt = (w_a_idx == c_LAST) ? '0 : w_a_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_w1_en   <= 1'b0;
            r_w2_en   <= 1'b0;
            r_w1_addr <= '0;
            r_w2_addr <= '0;
            r_w1_data <= '0;
            r_w2_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_w1_en <= w_a_vld;
            r_w2_en <= w_b_vld;
            // Address/data hold their last value when the port is idle
            if (w_a_vld) begin
                r_w1_addr <= w_addr[w_a_idx];
                r_w1_data <= w_data[w_a_idx];
            end
            if (w_b_vld) begin
                r_w2_addr <= w_addr[w_b_idx];
                r_w2_data <= w_data[w_b_idx];
            end
            r_busy <= |(bus.req_valid_i & ~w_ready);
        end
    end

    assign bus.req_ready_o   = w_ready;
    assign bus.write1_en_o   = r_w1_en;
    assign bus.write1_addr_o = r_w1_addr;
    assign bus.write1_data_o = r_w1_data;
    assign bus.write2_en_o   = r_w2_en;
    assign bus.write2_addr_o = r_w2_addr;
    assign bus.write2_data_o = r_w2_data;
    assign bus.busy_o        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// tb_rf_write_arbiter : directed self-checking bench for rf_write_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rf_write_arbiter_if #(.NUM_REQ(NR), .OPRAND_WIDTH(DW), .REGNAME_WIDTH(AW)) bus ();

    rf_write_arbiter #(
        .NUM_REQ      (NR),
        .OPRAND_WIDTH (DW),
        .REGNAME_WIDTH(AW),
        .DROP_R0      (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid_i[k]         = v;
        bus.req_addr_i[k*AW +: AW] = a;
        bus.req_data_i[k*DW +: DW] = d;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = '0;
        edge_step();
        edge_step();
        rst = 1'b0;
    endtask

    task automatic chk_w1(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_w1en"},   64'(bus.write1_en_o),   64'(en));
        chk({tag, "_w1addr"}, 64'(bus.write1_addr_o), 64'(a));
        chk({tag, "_w1data"}, 64'(bus.write1_data_o), 64'(d));
    endtask

    task automatic chk_w2(input string tag, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_w2en"},   64'(bus.write2_en_o),   64'(en));
        chk({tag, "_w2addr"}, 64'(bus.write2_addr_o), 64'(a));
        chk({tag, "_w2data"}, 64'(bus.write2_data_o), 64'(d));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;

        // Reset held for 3 cycles with every requester valid
        set_req(0, 1'b1, 5'd1, 32'hA000_0001);
        set_req(1, 1'b1, 5'd2, 32'hA000_0002);
        set_req(2, 1'b1, 5'd3, 32'hA000_0003);
        set_req(3, 1'b1, 5'd4, 32'hA000_0004);
        for (int c = 0; c < 3; c++) begin
            edge_step();
            chk("rst_ready", 64'(bus.req_ready_o), 64'h0);
            chk_w1("rst", 1'b0, 5'd0, 32'h0);
            chk_w2("rst", 1'b0, 5'd0, 32'h0);
            chk("rst_busy", 64'(bus.busy_o), 64'h0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready_o), 64'b0011);
        edge_step();
        chk_w1("post_rst", 1'b1, 5'd1, 32'hA000_0001);
        chk_w2("post_rst", 1'b1, 5'd2, 32'hA000_0002);

        // Single requester 2
        do_reset();
        set_req(2, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(bus.req_ready_o), 64'b0100);
        edge_step();
        chk_w1("single", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("single_w2en", 64'(bus.write2_en_o), 64'h0);
        // ptr now 3: requester 3 wins port 1 over requester 0
        bus.req_valid_i = '0;
        set_req(3, 1'b1, 5'd8, 32'hB000_0003);
        set_req(0, 1'b1, 5'd9, 32'hB000_0000);
        #1;
        chk("ptr3_ready", 64'(bus.req_ready_o), 64'b1001);
        edge_step();
        chk_w1("ptr3", 1'b1, 5'd8, 32'hB000_0003);
        chk_w2("ptr3", 1'b1, 5'd9, 32'hB000_0000);

        // All four valid, distinct addresses
        do_reset();
        set_req(0, 1'b1, 5'd1, 32'hC000_0001);
        set_req(1, 1'b1, 5'd2, 32'hC000_0002);
        set_req(2, 1'b1, 5'd3, 32'hC000_0003);
        set_req(3, 1'b1, 5'd4, 32'hC000_0004);
        #1;
        chk("all4_c1_ready", 64'(bus.req_ready_o), 64'b0011);
        edge_step();
        chk_w1("all4_c2", 1'b1, 5'd1, 32'hC000_0001);
        chk_w2("all4_c2", 1'b1, 5'd2, 32'hC000_0002);
        bus.req_valid_i[0] = 1'b0;
        bus.req_valid_i[1] = 1'b0;
        #1;
        chk("all4_c2_ready", 64'(bus.req_ready_o), 64'b1100);
        edge_step();
        chk_w1("all4_c3", 1'b1, 5'd3, 32'hC000_0003);
        chk_w2("all4_c3", 1'b1, 5'd4, 32'hC000_0004);
        // ptr wrapped to 0: requester 0 takes port 1
        bus.req_valid_i = '0;
        set_req(0, 1'b1, 5'd14, 32'hC000_0010);
        set_req(2, 1'b1, 5'd15, 32'hC000_0012);
        #1;
        chk("wrap_ready", 64'(bus.req_ready_o), 64'b0101);
        edge_step();
        chk_w1("wrap", 1'b1, 5'd14, 32'hC000_0010);
        chk_w2("wrap", 1'b1, 5'd15, 32'hC000_0012);

        // Same-address conflict: req1 deferred
        do_reset();
        set_req(0, 1'b1, 5'd7, 32'hD000_0000);
        set_req(1, 1'b1, 5'd7, 32'hD000_0001);
        set_req(2, 1'b1, 5'd9, 32'hD000_0002);
        #1;
        chk("conf_ready", 64'(bus.req_ready_o), 64'b0101);
        edge_step();
        chk_w1("conf", 1'b1, 5'd7, 32'hD000_0000);
        chk_w2("conf", 1'b1, 5'd9, 32'hD000_0002);
        chk("conf_busy", 64'(bus.busy_o), 64'h1);
        bus.req_valid_i[0] = 1'b0;
        bus.req_valid_i[2] = 1'b0;
        #1;
        chk("conf2_ready", 64'(bus.req_ready_o), 64'b0010);
        edge_step();
        chk_w1("conf2", 1'b1, 5'd7, 32'hD000_0001);
        chk("conf2_w2en", 64'(bus.write2_en_o), 64'h0);
        chk("conf2_busy", 64'(bus.busy_o), 64'h0);
        // Idle cycle: enables drop, address/data hold
        bus.req_valid_i = '0;
        edge_step();
        chk_w1("idle", 1'b0, 5'd7, 32'hD000_0001);
        chk_w2("idle", 1'b0, 5'd9, 32'hD000_0002);

        // r0 drop
        do_reset();
        set_req(1, 1'b1, 5'd0, 32'hE000_0001);
        set_req(3, 1'b1, 5'd6, 32'hE000_0003);
        #1;
        chk("r0_ready", 64'(bus.req_ready_o), 64'b1010);
        edge_step();
        chk_w1("r0", 1'b1, 5'd6, 32'hE000_0003);
        chk("r0_w2en", 64'(bus.write2_en_o), 64'h0);
        // ptr back at 0: requester 1 leads requester 2
        bus.req_valid_i = '0;
        set_req(1, 1'b1, 5'd3, 32'hE000_0011);
        set_req(2, 1'b1, 5'd4, 32'hE000_0012);
        #1;
        edge_step();
        chk_w1("r0_ptr", 1'b1, 5'd3, 32'hE000_0011);
        chk_w2("r0_ptr", 1'b1, 5'd4, 32'hE000_0012);

        // Asynchronous reset mid-cycle discards registered writes
        do_reset();
        set_req(0, 1'b1, 5'd10, 32'hF000_0000);
        set_req(1, 1'b1, 5'd11, 32'hF000_0001);
        #1;
        edge_step();
        chk("mid_pre_w1en", 64'(bus.write1_en_o), 64'h1);
        chk("mid_pre_w2en", 64'(bus.write2_en_o), 64'h1);
        bus.req_valid_i = '0;
        #1;
        rst = 1'b1;
        #1;
        chk_w1("mid_rst", 1'b0, 5'd0, 32'h0);
        chk_w2("mid_rst", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_req(1, 1'b1, 5'd20, 32'hF000_0011);
        set_req(3, 1'b1, 5'd21, 32'hF000_0013);
        #1;
        chk("mid_after_ready", 64'(bus.req_ready_o), 64'b1010);
        edge_step();
        chk_w1("mid_after", 1'b1, 5'd20, 32'hF000_0011);
        chk_w2("mid_after", 1'b1, 5'd21, 32'hF000_0013);

        bus.req_valid_i = '0;
        edge_step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
